watch_time_tx: RTL

Transmit-side formatter for the stopwatch/watch UART link. On a send request it snapshots the current watch time (hour/min/sec/msec from the watch datapath), converts each field to two ASCII decimal digits and streams the frame "HH:MM:SS.CC" plus optional CR LF, one byte at a time, into the UART transmitter through a start/busy/done handshake. It sits between the watch datapath outputs and the UART TX core, mirroring the UART RX path that feeds commands into the watch.

---
 rtl/watch_time_tx_if.sv | 13 +
 rtl/watch_time_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/watch_time_tx_if.sv
// watch_time_tx_if: byte handshake between the time formatter and the UART TX core.
//   o_tx_data  : byte to transmit, valid while o_tx_start is high
//   o_tx_start : one-cycle start pulse toward the UART TX
//   i_tx_busy  : UART TX is shifting a byte
//   i_tx_done  : one-cycle pulse when a byte has fully left the line
interface watch_time_tx_if;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_busy;
    logic       i_tx_done;
    modport master (output o_tx_data, o_tx_start, input i_tx_busy, i_tx_done);
    modport slave  (input o_tx_data, o_tx_start, output i_tx_busy, i_tx_done);
endinterface

// File: rtl/watch_time_tx.sv
// watch_time_tx: snapshots the watch time and streams "HH:MM:SS.CC"[CR LF] to a UART TX.
//   clk, rst         : clock, synchronous active-high reset
//   i_send           : frame request, honoured only when idle
//   hour/min/sec/msec: live watch time, captured on an accepted request
//   tx               : byte handshake to the UART TX core (master side)
//   o_busy           : frame in progress
//   o_done           : one-cycle pulse after the last byte has left the line
module watch_time_tx #(
    parameter bit ADD_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_send,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    watch_time_tx_if.master tx,
    output logic       o_busy,
    output logic       o_done
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [3:0] LAST      = ADD_CRLF ? 4'd12 : 4'd10;

    logic [1:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] msec_q, msec_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] frame_byte;

    // Fields above 99 saturate so every field is always exactly two digits.
    function automatic logic [7:0] asc(input logic [6:0] v, input logic tens);
        logic [6:0] s;
        s = (v > 7'd99) ? 7'd99 : v;
        return 8'h30 + {1'b0, tens ? s / 7'd10 : s % 7'd10};
    endfunction

    always_comb begin
        frame_byte = 8'h0A;
        case (idx_q)
            4'd0:    frame_byte = asc({2'b0, hour_q}, 1'b1);
            4'd1:    frame_byte = asc({2'b0, hour_q}, 1'b0);
            4'd2:    frame_byte = 8'h3A;
            4'd3:    frame_byte = asc({1'b0, min_q}, 1'b1);
            4'd4:    frame_byte = asc({1'b0, min_q}, 1'b0);
            4'd5:    frame_byte = 8'h3A;
            4'd6:    frame_byte = asc({1'b0, sec_q}, 1'b1);
            4'd7:    frame_byte = asc({1'b0, sec_q}, 1'b0);
            4'd8:    frame_byte = 8'h2E;
            4'd9:    frame_byte = asc(msec_q, 1'b1);
            4'd10:   frame_byte = asc(msec_q, 1'b0);
            4'd11:   frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        msec_d     = msec_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (i_send) begin
                hour_d  = hour;
                min_d   = min;
                sec_d   = sec;
                msec_d  = msec;
                idx_d   = 4'd0;
                state_d = SEND;
            end
            SEND: if (!tx.i_tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = frame_byte;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: if (tx.i_tx_done) begin
                state_d = (idx_q == LAST) ? IDLE : SEND;
                done_d  = (idx_q == LAST);
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            msec_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            msec_q     <= msec_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx.o_tx_data  = tx_data_q;
    assign tx.o_tx_start = tx_start_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
endmodule
